// File: rtl/contador_pulsador.sv
// contador_pulsador
//   Debounces two raw active-low push-buttons (up/down) and keeps a 4-bit
//   count. The count is presented as individual bits for the downstream
//   7-segment decoder. The block also has a synchronous load path and a
//   one-cycle wrap pulse.
//
// Ports:
//   clk        system clock; all logic updates on its rising edge
//   rst_n      synchronous active-low reset
//   btn_up_n   raw up button, active-low, asynchronous to clk, bouncy
//   btn_down_n raw down button, active-low, asynchronous to clk, bouncy
//   load_en    synchronous load strobe, active-high, highest priority
//   load_val   value taken by the count when load_en = 1
//   A, B, C, D count[3] (MSB) .. count[0] (LSB), straight from the register
//   wrap       one-cycle pulse on 15->0 (up) or 0->15 (down)
//
// Build option:
//   CONTADOR_SAT_EN  when defined, the count saturates at 0 and 15 instead
//                    of wrapping, and wrap is held at 0.

// Debounce FSM for one synchronized, active-high press signal. It issues a
// single registered step pulse for each press that stays stable for
// DEBOUNCE_CYCLES samples. A release must also stay stable for
// DEBOUNCE_CYCLES samples before the next press can be accepted.
module contador_pulsador_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic press_s,
  output logic step
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    HELD,
    WAIT_RELEASE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      step  <= 1'b0;
    end else begin
      step <= 1'b0;
      unique case (state)
        IDLE: begin
          if (press_s) begin
            state <= WAIT_PRESS;
            cnt   <= CW'(1);
          end
        end
        WAIT_PRESS: begin
          if (!press_s) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            state <= HELD;
            step  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!press_s) begin
            state <= WAIT_RELEASE;
            cnt   <= CW'(1);
          end
        end
        WAIT_RELEASE: begin
          if (press_s) begin
            state <= HELD;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

module contador_pulsador #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up_n,
  input  logic       btn_down_n,
  input  logic       load_en,
  input  logic [3:0] load_val,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       wrap
);

  // Two-flop synchronizers. They reset to 1, which means "released".
  logic [1:0] sync_up;
  logic [1:0] sync_down;
  logic       press_up;
  logic       press_down;
  logic       step_up;
  logic       step_down;
  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_up   <= '1;
      sync_down <= '1;
    end else begin
      sync_up   <= {sync_up[0], btn_up_n};
      sync_down <= {sync_down[0], btn_down_n};
    end
  end

  assign press_up   = ~sync_up[1];
  assign press_down = ~sync_down[1];

  contador_pulsador_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_up (
    .clk    (clk),
    .rst_n  (rst_n),
    .press_s(press_up),
    .step   (step_up)
  );

  contador_pulsador_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_down (
    .clk    (clk),
    .rst_n  (rst_n),
    .press_s(press_down),
    .step   (step_down)
  );

  // Priority order: load, then simultaneous up+down (cancel), then up, then down.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load_en) begin
        count <= load_val;
      end else if (step_up && step_down) begin
        count <= count;
      end else if (step_up) begin
`ifdef CONTADOR_SAT_EN
        if (count != 4'hF) count <= count + 1'b1;
`else
        count <= count + 1'b1;
        wrap  <= (count == 4'hF);
`endif
      end else if (step_down) begin
`ifdef CONTADOR_SAT_EN
        if (count != 4'h0) count <= count - 1'b1;
`else
        count <= count - 1'b1;
        wrap  <= (count == 4'h0);
`endif
      end
    end
  end

  assign A = count[3];
  assign B = count[2];
  assign C = count[1];
  assign D = count[0];

endmodule

// File: tb/tb_contador_pulsador.sv
module tb_contador_pulsador;

  logic       clk;
  logic       rst_n;
  logic       btn_up_n;
  logic       btn_down_n;
  logic       load_en;
  logic [3:0] load_val;
  logic       A, B, C, D;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  contador_pulsador #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_up_n  (btn_up_n),
    .btn_down_n(btn_down_n),
    .load_en   (load_en),
    .load_val  (load_val),
    .A         (A),
    .B         (B),
    .C         (C),
    .D         (D),
    .wrap      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       load_en;
    logic [3:0] load_val;
    logic [3:0] exp_count;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [3:0] cnt_now();
    return {A, B, C, D};
  endfunction

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Press the selected buttons together, hold them for 20 cycles, then
  // release. The new count must appear exactly 7 edges after the falling
  // edge (2 sync + 4 debounce + 1 count update). wrap must pulse for that
  // one cycle only.
  task automatic press_check(input string name, input logic up, input logic down,
                             input logic [3:0] old_cnt, input logic [3:0] new_cnt,
                             input logic exp_wrap);
    if (up)   btn_up_n   = 1'b0;
    if (down) btn_down_n = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check({name, "_cnt"}, cnt_now(), (k >= 7) ? new_cnt : old_cnt);
      check({name, "_wrap"}, wrap, (k == 7) ? exp_wrap : 1'b0);
    end
    btn_up_n   = 1'b1;
    btn_down_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      check({name, "_rel_cnt"}, cnt_now(), new_cnt);
      check({name, "_rel_wrap"}, wrap, 1'b0);
    end
  endtask

  task automatic do_load(input logic [3:0] v);
    load_en  = 1'b1;
    load_val = v;
    tick();
    load_en  = 1'b0;
    check("load", cnt_now(), v);
  endtask

  initial begin
    vecs[0] = '{1'b1, 4'h5, 4'h5, 1'b0};
    vecs[1] = '{1'b0, 4'h9, 4'h5, 1'b0};
    vecs[2] = '{1'b1, 4'hA, 4'hA, 1'b0};
    vecs[3] = '{1'b1, 4'h0, 4'h0, 1'b0};
    vecs[4] = '{1'b0, 4'hF, 4'h0, 1'b0};
    vecs[5] = '{1'b1, 4'hF, 4'hF, 1'b0};
    vecs[6] = '{1'b1, 4'h3, 4'h3, 1'b0};
    vecs[7] = '{1'b0, 4'hC, 4'h3, 1'b0};

    rst_n      = 1'b0;
    btn_up_n   = 1'b1;
    btn_down_n = 1'b1;
    load_en    = 1'b0;
    load_val   = 4'h0;
    repeat (3) tick();
    check("init_cnt", cnt_now(), 0);
    check("init_wrap", wrap, 0);
    rst_n = 1'b1;
    repeat (8) tick();

    // Reset with the up button held low: outputs stay clear while reset is
    // asserted, and exactly one increment follows once reset is released.
    load_en  = 1'b1;
    load_val = 4'h6;
    tick();
    load_en  = 1'b0;
    rst_n    = 1'b0;
    btn_up_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_cnt", cnt_now(), 0);
      check("rst_wrap", wrap, 0);
    end
    rst_n = 1'b1;
    press_check("rst_release", 1'b1, 1'b0, 4'h0, 4'h1, 1'b0);

    // Load path, applied from the vector table.
    for (int i = 0; i < 8; i++) begin
      load_en  = vecs[i].load_en;
      load_val = vecs[i].load_val;
      tick();
      check("vec_cnt", cnt_now(), vecs[i].exp_count);
      check("vec_wrap", wrap, vecs[i].exp_wrap);
    end
    load_en = 1'b0;

    // Clean press from 3 gives 4.
    press_check("clean_up", 1'b1, 1'b0, 4'h3, 4'h4, 1'b0);
    press_check("clean_down", 1'b0, 1'b1, 4'h4, 4'h3, 1'b0);

    // Bounce: toggle every 2 cycles, then 3-low/1-high glitches.
    for (int i = 0; i < 16; i++) begin
      btn_up_n = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      check("bounce2_cnt", cnt_now(), 3);
    end
    btn_up_n = 1'b1;
    repeat (10) begin
      tick();
      check("bounce2_tail", cnt_now(), 3);
    end
    for (int i = 0; i < 16; i++) begin
      btn_up_n = ((i % 4) == 3) ? 1'b1 : 1'b0;
      tick();
      check("bounce3_cnt", cnt_now(), 3);
    end
    btn_up_n = 1'b1;
    repeat (10) begin
      tick();
      check("bounce3_tail", cnt_now(), 3);
    end

    // Wrap or saturate at the ends of the range.
`ifdef CONTADOR_SAT_EN
    do_load(4'hF);
    press_check("sat_up", 1'b1, 1'b0, 4'hF, 4'hF, 1'b0);
    do_load(4'h0);
    press_check("sat_down", 1'b0, 1'b1, 4'h0, 4'h0, 1'b0);
`else
    do_load(4'hF);
    press_check("wrap_up", 1'b1, 1'b0, 4'hF, 4'h0, 1'b1);
    press_check("wrap_down", 1'b0, 1'b1, 4'h0, 4'hF, 1'b1);
`endif

    // Both buttons pressed in lockstep, so both pulses land in the same
    // cycle and the count holds.
    do_load(4'h7);
    press_check("both", 1'b1, 1'b1, 4'h7, 4'h7, 1'b0);

    // load_en during the same cycle as the up pulse: the load wins.
    do_load(4'h2);
    btn_up_n = 1'b0;
    repeat (6) begin
      tick();
      check("ldpulse_pre", cnt_now(), 2);
    end
    load_en  = 1'b1;
    load_val = 4'hA;
    tick();
    load_en  = 1'b0;
    check("ldpulse_cnt", cnt_now(), 4'hA);
    check("ldpulse_wrap", wrap, 0);
    repeat (6) begin
      tick();
      check("ldpulse_hold", cnt_now(), 4'hA);
    end
    btn_up_n = 1'b1;
    repeat (10) begin
      tick();
      check("ldpulse_rel", cnt_now(), 4'hA);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
